// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP issue controller.
//   fpu_op_e        - operation select driven to the FPU (add/sub/mul/div)
//   issue_state_e   - controller FSM state encoding
//   FP_QNAN         - quiet NaN written back when an operation times out
//   TIMEOUT_DEFAULT - default EXEC cycle budget before abort
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } issue_state_e;

    localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
    localparam int          TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: bundle of every non-clock/reset signal of the issue
// controller.
//   slave  modport - controller view (request in, FPU drive out, writeback out)
//   master modport - environment view (pipeline, FPU and writeback consumer)
interface fpu_issue_ctrl_if;

    // pipeline request
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    // FPU side
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_sel;
    logic        pipe_stall;
    logic        fpu_stall;
    logic        fpu_done;
    logic        fpu_ovf;
    logic        fpu_unf;
    logic [31:0] fpu_result;
    // writeback
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  wb_flags;
    // status
    logic        busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        output req_ready,
        output fpu_a, fpu_b, fpu_sel, fpu_stall,
        input  pipe_stall, fpu_done, fpu_ovf, fpu_unf, fpu_result,
        output wb_valid, wb_rd, wb_data, wb_flags,
        input  wb_ready,
        output busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        input  req_ready,
        input  fpu_a, fpu_b, fpu_sel, fpu_stall,
        output pipe_stall, fpu_done, fpu_ovf, fpu_unf, fpu_result,
        input  wb_valid, wb_rd, wb_data, wb_flags,
        output wb_ready,
        input  busy
    );

endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one FP operation at a time to an external FPU,
// waits for completion (or aborts after TIMEOUT unstalled EXEC cycles) and
// presents the result on a valid/ready writeback port.
//   clk  - clock, all state on rising edge
//   rstn - asynchronous active-low reset
//   bus  - request, FPU and writeback signals (slave modport)
//          wb_flags = {timeout, overflow, underflow}
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    fpu_issue_ctrl_if.slave       bus
);

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    issue_state_e     state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      fpu_a_q,    fpu_a_d;
    logic [31:0]      fpu_b_q,    fpu_b_d;
    fpu_op_e          fpu_sel_q,  fpu_sel_d;
    logic [4:0]       wb_rd_q,    wb_rd_d;
    logic [31:0]      wb_data_q,  wb_data_d;
    logic [2:0]       wb_flags_q, wb_flags_d;
    logic             fpu_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fpu_a_q    <= '0;
            fpu_b_q    <= '0;
            fpu_sel_q  <= OP_ADD;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fpu_a_q    <= fpu_a_d;
            fpu_b_q    <= fpu_b_d;
            fpu_sel_q  <= fpu_sel_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_flags_q <= wb_flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fpu_a_d    = fpu_a_q;
        fpu_b_d    = fpu_b_q;
        fpu_sel_d  = fpu_sel_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_flags_d = wb_flags_q;
        fpu_stall  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    fpu_a_d   = bus.req_a;
                    fpu_b_d   = bus.req_b;
                    fpu_sel_d = fpu_op_e'(bus.req_op);
                    wb_rd_d   = bus.req_rd;
                    cnt_d     = '0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                fpu_stall = bus.pipe_stall;
                // A completion in the same cycle as the budget expiring wins.
                if (bus.fpu_done) begin
                    wb_data_d  = bus.fpu_result;
                    wb_flags_d = {1'b0, bus.fpu_ovf, bus.fpu_unf};
                    state_d    = ST_WB;
                end else if (cnt_q == CNT_LAST) begin
                    wb_data_d  = FP_QNAN;
                    wb_flags_d = 3'b100;
                    state_d    = ST_WB;
                end else if (!bus.pipe_stall) begin
                    // Frozen cycles do not consume the timeout budget.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                // Return to IDLE only; a new request waits for the next cycle.
                if (bus.wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.wb_valid  = (state_q == ST_WB);
    assign bus.fpu_stall = fpu_stall;
    assign bus.fpu_a     = fpu_a_q;
    assign bus.fpu_b     = fpu_b_q;
    assign bus.fpu_sel   = fpu_sel_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_flags  = wb_flags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed self-checking bench for fpu_issue_ctrl.
// The bench plays pipeline, FPU and writeback consumer through the interface.
module tb_fpu_issue_ctrl;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl #(.TIMEOUT(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fpu_a"},    bus.fpu_a,    32'h0);
        check({tag, "_fpu_b"},    bus.fpu_b,    32'h0);
        check({tag, "_fpu_sel"},  {30'd0, bus.fpu_sel}, 32'h0);
        check({tag, "_wb_data"},  bus.wb_data,  32'h0);
        check({tag, "_wb_flags"}, {29'd0, bus.wb_flags}, 32'h0);
        check({tag, "_wb_rd"},    {27'd0, bus.wb_rd},    32'h0);
        check({tag, "_wb_valid"}, {31'd0, bus.wb_valid}, 32'h0);
        check({tag, "_busy"},     {31'd0, bus.busy},     32'h0);
        check({tag, "_fpu_stall"},{31'd0, bus.fpu_stall},32'h0);
        check({tag, "_req_ready"},{31'd0, bus.req_ready},32'h1);
    endtask

    // Drives a request for one cycle; on return the DUT is in its first EXEC cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        tick();
        bus.req_valid = 1'b0;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'hDEAD_BEEF;
        bus.req_op    = 2'b00;
        bus.req_rd    = 5'd31;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.req_rd     = 5'd0;
        bus.pipe_stall = 1'b0;
        bus.fpu_done   = 1'b0;
        bus.fpu_ovf    = 1'b0;
        bus.fpu_unf    = 1'b0;
        bus.fpu_result = 32'h0;
        bus.wb_ready   = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check_reset_outputs("rst");
        rstn = 1'b1;
        tick();
        check("rst_release_ready", {31'd0, bus.req_ready}, 32'h1);
        $display("txn reset released");

        // ---- add: done in first EXEC cycle, wb_valid on cycle 2 ----
        bus.fpu_done   = 1'b1;   // asserted in IDLE too; must be ignored there
        bus.fpu_result = 32'h4040_0000;
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd3);
        check("add_c1_busy",     {31'd0, bus.busy},      32'h1);
        check("add_c1_ready",    {31'd0, bus.req_ready}, 32'h0);
        check("add_c1_wbvalid",  {31'd0, bus.wb_valid},  32'h0);
        check("add_fpu_a",       bus.fpu_a,              32'h3F80_0000);
        check("add_fpu_b",       bus.fpu_b,              32'h4000_0000);
        check("add_fpu_sel",     {30'd0, bus.fpu_sel},   32'h0);
        tick();
        bus.fpu_done = 1'b0;
        check("add_c2_wbvalid",  {31'd0, bus.wb_valid},  32'h1);
        check("add_wb_data",     bus.wb_data,            32'h4040_0000);
        check("add_wb_flags",    {29'd0, bus.wb_flags},  32'h0);
        check("add_wb_rd",       {27'd0, bus.wb_rd},     32'd3);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        check("add_back_idle",   {31'd0, bus.req_ready}, 32'h1);
        check("add_wb_dropped",  {31'd0, bus.wb_valid},  32'h0);
        $display("txn add rd=3 data=%h flags=%b", 32'h4040_0000, 3'b000);

        // ---- div: done after 26 EXEC cycles, 5 of them stalled ----
        issue(2'b11, 32'h4120_0000, 32'h4040_0000, 5'd7);
        for (int i = 0; i < 26; i++) begin
            bus.pipe_stall = (i >= 10 && i < 15);
            bus.fpu_done   = (i == 25);
            bus.fpu_result = 32'h4055_5555;
            #1;
            check($sformatf("div_stall_%0d", i), {31'd0, bus.fpu_stall}, {31'd0, bus.pipe_stall});
            check($sformatf("div_a_%0d", i),     bus.fpu_a,              32'h4120_0000);
            check($sformatf("div_b_%0d", i),     bus.fpu_b,              32'h4040_0000);
            check($sformatf("div_sel_%0d", i),   {30'd0, bus.fpu_sel},   32'h3);
            check($sformatf("div_wbv_%0d", i),   {31'd0, bus.wb_valid},  32'h0);
            tick();
        end
        bus.fpu_done   = 1'b0;
        bus.pipe_stall = 1'b1;
        #1;
        check("div_wbvalid",     {31'd0, bus.wb_valid},  32'h1);
        check("div_wb_data",     bus.wb_data,            32'h4055_5555);
        check("div_wb_flags",    {29'd0, bus.wb_flags},  32'h0);
        check("div_wb_rd",       {27'd0, bus.wb_rd},     32'd7);
        check("div_wb_nostall",  {31'd0, bus.fpu_stall}, 32'h0);
        check("div_wb_a_hold",   bus.fpu_a,              32'h4120_0000);
        bus.pipe_stall = 1'b0;
        bus.wb_ready   = 1'b1;
        tick();
        bus.wb_ready   = 1'b0;
        check("div_back_idle",   {31'd0, bus.req_ready}, 32'h1);
        $display("txn div rd=7 data=%h flags=%b", 32'h4055_5555, 3'b000);

        // ---- timeout: fpu_done never asserted ----
        issue(2'b11, 32'h3F80_0000, 32'h0000_0000, 5'd21);
        for (int n = 0; n < 64; n++) begin
            if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b1) begin
                check($sformatf("to_early_%0d", n), {30'd0, bus.wb_valid, bus.busy}, 32'h1);
            end
            tick();
        end
        total++;   // the 64-cycle window was watched above
        check("to_wbvalid",      {31'd0, bus.wb_valid},  32'h1);
        check("to_wb_data",      bus.wb_data,            32'h7FC0_0000);
        check("to_wb_flags",     {29'd0, bus.wb_flags},  32'h4);
        check("to_wb_rd",        {27'd0, bus.wb_rd},     32'd21);
        $display("txn timeout rd=21 data=%h flags=%b", 32'h7FC0_0000, 3'b100);

        // ---- writeback back-pressure, request ignored while in WB ----
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_a     = 32'h1111_1111;
        bus.req_b     = 32'h2222_2222;
        bus.req_rd    = 5'd9;
        bus.fpu_done  = 1'b1;   // ignored outside EXEC
        bus.fpu_result = 32'h3333_3333;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("bp_wbv_%0d", k),   {31'd0, bus.wb_valid},  32'h1);
            check($sformatf("bp_data_%0d", k),  bus.wb_data,            32'h7FC0_0000);
            check($sformatf("bp_flags_%0d", k), {29'd0, bus.wb_flags},  32'h4);
            check($sformatf("bp_rd_%0d", k),    {27'd0, bus.wb_rd},     32'd21);
            check($sformatf("bp_ready_%0d", k), {31'd0, bus.req_ready}, 32'h0);
            check($sformatf("bp_a_%0d", k),     bus.fpu_a,              32'h3F80_0000);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready  = 1'b0;
        bus.req_valid = 1'b0;
        bus.fpu_done  = 1'b0;
        check("bp_idle_busy",    {31'd0, bus.busy},      32'h0);
        check("bp_idle_ready",   {31'd0, bus.req_ready}, 32'h1);
        check("bp_not_taken_a",  bus.fpu_a,              32'h3F80_0000);
        $display("txn backpressure released after 10 cycles");

        // ---- reset mid-EXEC ----
        issue(2'b10, 32'h4000_0000, 32'h4000_0000, 5'd9);
        tick();
        tick();
        check("rx_busy_before",  {31'd0, bus.busy},      32'h1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("rx");
        tick();
        rstn = 1'b1;
        tick();
        $display("txn reset during EXEC");

        // ---- mul overflow after reset ----
        bus.fpu_done   = 1'b1;
        bus.fpu_ovf    = 1'b1;
        bus.fpu_result = 32'h7F80_0000;
        issue(2'b10, 32'h7F00_0000, 32'h7F00_0000, 5'd12);
        check("ovf_fpu_sel",     {30'd0, bus.fpu_sel},   32'h2);
        tick();
        bus.fpu_done = 1'b0;
        bus.fpu_ovf  = 1'b0;
        check("ovf_wbvalid",     {31'd0, bus.wb_valid},  32'h1);
        check("ovf_wb_data",     bus.wb_data,            32'h7F80_0000);
        check("ovf_wb_flags",    {29'd0, bus.wb_flags},  32'h2);
        check("ovf_wb_rd",       {27'd0, bus.wb_rd},     32'd12);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        $display("txn mul rd=12 data=%h flags=%b", 32'h7F80_0000, 3'b010);

        // ---- sub underflow ----
        bus.fpu_done   = 1'b1;
        bus.fpu_unf    = 1'b1;
        bus.fpu_result = 32'h0000_0000;
        issue(2'b01, 32'h0080_0001, 32'h0080_0000, 5'd30);
        tick();
        bus.fpu_done = 1'b0;
        bus.fpu_unf  = 1'b0;
        check("unf_wb_flags",    {29'd0, bus.wb_flags},  32'h1);
        check("unf_wb_rd",       {27'd0, bus.wb_rd},     32'd30);
        check("unf_fpu_sel",     {30'd0, bus.fpu_sel},   32'h1);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        $display("txn sub rd=30 data=%h flags=%b", 32'h0, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, maximum EXEC cycles allowed before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents an FP operation.
REQ-005 SHALL have port req_ready  output  1  block can accept an operation.
REQ-006 SHALL have port req_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have ports req_a, req_b  input  32  IEEE-754 single operands.
REQ-008 SHALL have port req_rd  input  5  destination register tag.
REQ-009 SHALL have ports fpu_a, fpu_b  output  32  registered operands to FPU.
REQ-010 SHALL have port fpu_sel  output  2  registered op select to FPU.
REQ-011 SHALL have port pipe_stall  input  1  pipeline freeze request.
REQ-012 SHALL have port fpu_stall  output  1  freeze to FPU divider.
REQ-013 SHALL have ports fpu_done, fpu_ovf, fpu_unf  input  1  FPU done_cal, overflow, underflow.
REQ-014 SHALL have port fpu_result  input  32  FPU alu_out.
REQ-015 SHALL have ports wb_valid output 1, wb_ready input 1  writeback handshake.
REQ-016 SHALL have ports wb_rd output 5, wb_data output 32, wb_flags output 3 ({timeout,ovf,unf})  writeback payload.
REQ-017 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, WB.
REQ-019 SHALL drive req_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with req_valid=1, register req_a/req_b/req_op/req_rd into fpu_a/fpu_b/fpu_sel/rd register, clear the timeout counter and go to EXEC.
REQ-021 SHALL hold fpu_a, fpu_b and fpu_sel stable in EXEC and WB; in IDLE they keep their last value.
REQ-022 SHALL drive fpu_stall = pipe_stall in EXEC, 0 otherwise.
REQ-023 SHALL sample fpu_done every EXEC cycle, including the first; on fpu_done=1, capture fpu_result into wb_data and {0,fpu_ovf,fpu_unf} into wb_flags, and go to WB.
REQ-024 SHALL yield minimum latency acceptance->wb_valid of 2 cycles (combinational add/sub/mul).
REQ-025 SHALL increment the timeout counter each EXEC cycle with fpu_stall=0 and fpu_done=0.
REQ-026 SHALL, when the counter reaches TIMEOUT-1 without fpu_done, load wb_data=32'h7FC00000 and wb_flags=3'b100 and go to WB.
REQ-027 SHALL give fpu_done priority over timeout in the same cycle.
REQ-028 SHALL assert wb_valid=1 exactly in WB, with wb_rd/wb_data/wb_flags stable until the handshake.
REQ-029 SHALL go WB->IDLE on wb_ready=1; no new request is accepted in that same cycle.
REQ-030 SHALL ignore req_valid outside IDLE and ignore fpu_done outside EXEC.
REQ-031 SHALL drive busy=1 in EXEC and WB.

Reset
REQ-032 SHALL, while rstn=0 (including mid-EXEC or mid-WB), force state IDLE, counter 0, fpu_a/fpu_b/wb_data 0, fpu_sel 00, wb_rd 0, wb_flags 0, wb_valid 0, discarding any pending result.
REQ-033 SHALL give req_ready=1 in the first cycle after rstn deasserts.

Structure
REQ-034 SHALL take op encodings, FSM state encoding, the qNaN constant and the TIMEOUT default from shared package fpu_pkg.
REQ-035 SHALL be a single module with the counter inline; no sub-module.

Verification
REQ-036 SHALL cover: add 3F800000+40000000, fpu_done in first EXEC -> wb_valid on cycle 2, wb_data=40400000, wb_flags=000.
REQ-037 SHALL cover: div with fpu_done after 26 cycles, pipe_stall high for 5 of them -> fpu_stall mirrors pipe_stall, no timeout, operands stable throughout.
REQ-038 SHALL cover: fpu_done never asserted -> wb_valid after exactly 64 EXEC cycles, wb_data=7FC00000, wb_flags=100.
REQ-039 SHALL cover: wb_ready held low 10 cycles -> wb_valid and payload stable, req_ready=0, req_valid ignored.
REQ-040 SHALL cover: rstn low mid-EXEC -> all outputs at reset values, next accepted op completes normally.
REQ-041 SHALL cover: mul overflow 7F000000*7F000000 with fpu_ovf=1 -> wb_flags=010.
